// File: rtl/anim_pkg.sv
// anim_pkg -- shared definitions for the animation scheduler.
//   state_t         : scheduler FSM states (idle animation / requested animation).
//   ANIM_*          : animation ids as used by the per-animation ROMs.
//   DEF_NUM_ANIM/DEF_FRAMES : default animation count and frames per animation.
package anim_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_PLAY
  } state_t;

  localparam int ANIM_IDLE  = 0;
  localparam int ANIM_HAPPY = 1;
  localparam int ANIM_SAD   = 2;
  localparam int ANIM_ANGRY = 3;

  localparam int DEF_NUM_ANIM = 4;
  localparam int DEF_FRAMES   = 16;

endpackage

// File: rtl/anim_scheduler_rr_arbiter.sv
// rr_arbiter -- combinational round-robin pick.
//   pending : request vector, one bit per animation.
//   ptr     : index where the search starts; search runs upward and wraps.
//   winner  : one-hot winning request (all zero when nothing is pending).
//   valid   : at least one request is pending.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     pending,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     winner,
  output logic             valid
);

  logic [N-1:0] upper_mask;
  logic [N-1:0] upper_req;

  // Bits at or above the pointer are searched first; if none is set the
  // search wraps to the bottom of the vector.
  for (genvar gi = 0; gi < N; gi++) begin : g_mask
    assign upper_mask[gi] = (PTR_W'(gi) >= ptr);
  end

  assign upper_req = pending & upper_mask;
  assign valid     = |pending;

  // x & -x isolates the lowest set bit.
  assign winner = (|upper_req) ? (upper_req & (~upper_req + N'(1)))
                               : (pending & (~pending + N'(1)));

endmodule

// File: rtl/anim_scheduler.sv
// anim_scheduler -- chooses which screen animation plays and its frame step.
//   clk        : system clock.
//   rst_n      : asynchronous active-low reset.
//   req        : per-animation request level, latched into a sticky pending set.
//   frame_sync : start-of-screen-frame pulse; frame changes happen only here.
//   anim_sel   : active animation id (to the animation ROMs).
//   step       : active frame index (to the animation ROMs).
//   busy       : a non-idle animation is playing.
//   grant      : one-hot, one-cycle pulse when an animation starts.
//   loop_done  : one-cycle pulse when step wraps to 0.
module anim_scheduler
  import anim_pkg::*;
#(
  parameter int NUM_ANIM  = DEF_NUM_ANIM,
  parameter int IDLE_ANIM = ANIM_IDLE,
  parameter int FRAMES    = DEF_FRAMES,
  parameter int TICK_W    = 24,
  parameter int MIN_LOOPS = 2,
  localparam int SEL_W    = (NUM_ANIM > 1) ? $clog2(NUM_ANIM) : 1,
  localparam int STEP_W   = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_ANIM-1:0] req,
  input  logic                frame_sync,
  output logic [SEL_W-1:0]    anim_sel,
  output logic [STEP_W-1:0]   step,
  output logic                busy,
  output logic [NUM_ANIM-1:0] grant,
  output logic                loop_done
);

  localparam int LOOP_W = (MIN_LOOPS > 0) ? $clog2(MIN_LOOPS + 1) : 1;
  localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(FRAMES - 1);
  localparam logic [LOOP_W-1:0]   LOOP_MIN  = LOOP_W'(MIN_LOOPS);
  localparam logic [SEL_W-1:0]    IDLE_ID   = SEL_W'(IDLE_ANIM);
  localparam logic [NUM_ANIM-1:0] IDLE_MASK = NUM_ANIM'(1) << IDLE_ANIM;

  state_t                state_reg, state_next;
  logic [TICK_W-1:0]     tick_cnt_reg;
  logic                  adv_pend_reg, adv_pend_next;
  logic [NUM_ANIM-1:0]   pending_reg, pending_next;
  logic [SEL_W-1:0]      anim_sel_reg, anim_sel_next;
  logic [STEP_W-1:0]     step_reg, step_next;
  logic [LOOP_W-1:0]     loop_cnt_reg, loop_cnt_next;
  logic [SEL_W-1:0]      rr_ptr_reg, rr_ptr_next;
  logic [NUM_ANIM-1:0]   grant_reg, grant_next;
  logic                  loop_done_reg, loop_done_next;

  logic                  tick;
  logic                  adv_now;
  logic                  wrap;
  logic [STEP_W-1:0]     step_inc;
  logic [LOOP_W-1:0]     loop_cnt_inc;
  logic                  playing;
  logic                  retrig;
  logic [NUM_ANIM-1:0]   cur_mask;
  logic [NUM_ANIM-1:0]   play_mask;
  logic [NUM_ANIM-1:0]   arb_in;
  logic [NUM_ANIM-1:0]   arb_winner;
  logic                  arb_valid;
  logic [SEL_W-1:0]      winner_idx;
  logic [SEL_W-1:0][NUM_ANIM-1:0] idx_terms;
  logic                  do_grant;

  // Frame tick, held in adv_pend until the next frame_sync so a step never
  // changes mid-scan; several ticks between syncs collapse into one advance.
  assign tick          = &tick_cnt_reg;
  assign adv_now       = (adv_pend_reg | tick) & frame_sync;
  assign adv_pend_next = (adv_pend_reg | tick) & ~frame_sync;

  assign wrap         = adv_now & (step_reg == STEP_LAST);
  assign step_inc     = (step_reg == STEP_LAST) ? '0 : step_reg + STEP_W'(1);
  assign loop_cnt_inc = (loop_cnt_reg >= LOOP_MIN) ? loop_cnt_reg
                                                   : loop_cnt_reg + LOOP_W'(1);

  for (genvar gi = 0; gi < NUM_ANIM; gi++) begin : g_cur
    assign cur_mask[gi] = (anim_sel_reg == SEL_W'(gi));
  end

  // A request for the animation already playing is a retrigger, never a
  // pending entry. A switch only happens without a retrigger, so masking the
  // current bit throughout PLAY loses nothing.
  assign playing   = (state_reg == ST_PLAY);
  assign play_mask = playing ? cur_mask : '0;
  assign retrig    = playing & (|(req & cur_mask));
  assign arb_in    = (pending_reg | req) & ~IDLE_MASK & ~play_mask;

  rr_arbiter #(
    .N (NUM_ANIM)
  ) u_rr_arbiter (
    .pending (arb_in),
    .ptr     (rr_ptr_reg),
    .winner  (arb_winner),
    .valid   (arb_valid)
  );

  // One-hot to binary: bit gb of the id is the OR of winners whose index has bit gb set.
  for (genvar gb = 0; gb < SEL_W; gb++) begin : g_idx_bit
    for (genvar gi = 0; gi < NUM_ANIM; gi++) begin : g_idx_term
      assign idx_terms[gb][gi] = (((gi >> gb) & 1) != 0) ? arb_winner[gi] : 1'b0;
    end
    assign winner_idx[gb] = |idx_terms[gb];
  end

  always_comb begin
    state_next     = state_reg;
    anim_sel_next  = anim_sel_reg;
    step_next      = step_reg;
    loop_cnt_next  = loop_cnt_reg;
    rr_ptr_next    = rr_ptr_reg;
    loop_done_next = wrap;
    do_grant       = 1'b0;

    if (adv_now) begin
      step_next = step_inc;
      if (wrap) begin
        loop_cnt_next = loop_cnt_inc;
      end
    end

    case (state_reg)
      ST_IDLE: begin
        if (frame_sync && arb_valid) begin
          do_grant = 1'b1;
        end
      end
      ST_PLAY: begin
        if (retrig) begin
          loop_cnt_next = '0;
        end else if (wrap && (loop_cnt_inc >= LOOP_MIN)) begin
          if (arb_valid) begin
            do_grant = 1'b1;
          end else begin
            state_next    = ST_IDLE;
            anim_sel_next = IDLE_ID;
            step_next     = '0;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // Starting an animation overrides any advance in the same cycle.
    if (do_grant) begin
      state_next    = ST_PLAY;
      anim_sel_next = winner_idx;
      step_next     = '0;
      loop_cnt_next = '0;
      rr_ptr_next   = (winner_idx == SEL_W'(NUM_ANIM - 1)) ? '0
                                                           : winner_idx + SEL_W'(1);
    end

    grant_next   = do_grant ? arb_winner : '0;
    // Granted bit is dropped here, so a req on it in the grant cycle is absorbed.
    pending_next = (pending_reg | req) & ~IDLE_MASK & ~play_mask & ~grant_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      tick_cnt_reg  <= '0;
      adv_pend_reg  <= 1'b0;
      pending_reg   <= '0;
      anim_sel_reg  <= IDLE_ID;
      step_reg      <= '0;
      loop_cnt_reg  <= '0;
      rr_ptr_reg    <= '0;
      grant_reg     <= '0;
      loop_done_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      tick_cnt_reg  <= tick_cnt_reg + TICK_W'(1);
      adv_pend_reg  <= adv_pend_next;
      pending_reg   <= pending_next;
      anim_sel_reg  <= anim_sel_next;
      step_reg      <= step_next;
      loop_cnt_reg  <= loop_cnt_next;
      rr_ptr_reg    <= rr_ptr_next;
      grant_reg     <= grant_next;
      loop_done_reg <= loop_done_next;
    end
  end

  assign anim_sel  = anim_sel_reg;
  assign step      = step_reg;
  assign busy      = playing;
  assign grant     = grant_reg;
  assign loop_done = loop_done_reg;

endmodule

// File: tb/tb_anim_scheduler.sv
// tb_anim_scheduler -- directed bench for anim_scheduler with a 4-cycle tick.
// Edges are numbered from reset release; with TICK_W=2 and frame_sync held
// high the step advances on every edge that is a multiple of 4.
module tb_anim_scheduler;
  import anim_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       frame_sync;
  logic [1:0] anim_sel;
  logic [3:0] step;
  logic       busy;
  logic [3:0] grant;
  logic       loop_done;

  int errors = 0;
  int checks = 0;
  int edge_n = 0;

  anim_scheduler #(
    .NUM_ANIM  (4),
    .IDLE_ANIM (0),
    .FRAMES    (16),
    .TICK_W    (2),
    .MIN_LOOPS (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .frame_sync (frame_sync),
    .anim_sel   (anim_sel),
    .step       (step),
    .busy       (busy),
    .grant      (grant),
    .loop_done  (loop_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after edge e (relative to the last reset release).
  task automatic adv_to(input int e);
    while (edge_n < e) begin
      @(posedge clk);
      #1;
      edge_n++;
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    req        = 4'b0000;
    frame_sync = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_anim_sel", 32'(anim_sel), ANIM_IDLE);
    chk("rst_step", 32'(step), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_loop_done", 32'(loop_done), 0);
    rst_n  = 1'b1;
    edge_n = 0;

    // Idle stepping
    adv_to(3);   chk("idle_step_e3", 32'(step), 0);
    adv_to(4);   chk("idle_step_e4", 32'(step), 1);
    adv_to(63);  chk("idle_step_e63", 32'(step), 15);
                 chk("idle_ld_e63", 32'(loop_done), 0);
    adv_to(64);  chk("idle_wrap_step", 32'(step), 0);
                 chk("idle_wrap_ld", 32'(loop_done), 1);
    adv_to(65);  chk("idle_ld_pulse", 32'(loop_done), 0);

    // Grant from idle, then return to idle after two loops
    req = 4'b0010;
    adv_to(66);  req = 4'b0000;
    chk("g1_grant", 32'(grant), 32'h2);
    chk("g1_sel", 32'(anim_sel), ANIM_HAPPY);
    chk("g1_step", 32'(step), 0);
    chk("g1_busy", 32'(busy), 1);
    adv_to(67);  chk("g1_grant_pulse", 32'(grant), 0);
    adv_to(128); chk("g1_loop1_ld", 32'(loop_done), 1);
                 chk("g1_loop1_sel", 32'(anim_sel), ANIM_HAPPY);
    adv_to(191); chk("g1_e191_step", 32'(step), 15);
                 chk("g1_e191_busy", 32'(busy), 1);
    adv_to(192); chk("g1_end_sel", 32'(anim_sel), ANIM_IDLE);
                 chk("g1_end_busy", 32'(busy), 0);
                 chk("g1_end_step", 32'(step), 0);

    // Frame sync gating
    frame_sync = 1'b0;
    adv_to(202); chk("fs_hold_step", 32'(step), 0);
    frame_sync = 1'b1;
    adv_to(203); frame_sync = 1'b0;
    chk("fs_once_step", 32'(step), 1);
    adv_to(206); chk("fs_no_repeat", 32'(step), 1);
    frame_sync = 1'b1;
    adv_to(207); chk("fs_pend_step", 32'(step), 2);
    adv_to(208); chk("fs_tick_step", 32'(step), 3);

    // Round-robin with sticky requests
    req = 4'b0010;
    adv_to(209); req = 4'b0000;
    chk("rr_g1_grant", 32'(grant), 32'h2);
    adv_to(210); req = 4'b1100;
    adv_to(211); req = 4'b0000;
    chk("rr_no_preempt_a", 32'(anim_sel), ANIM_HAPPY);
    adv_to(272); chk("rr_loop1_ld", 32'(loop_done), 1);
                 chk("rr_no_preempt_b", 32'(anim_sel), ANIM_HAPPY);
    adv_to(335); chk("rr_e335_sel", 32'(anim_sel), ANIM_HAPPY);
    adv_to(336); chk("rr_g2_grant", 32'(grant), 32'h4);
                 chk("rr_g2_sel", 32'(anim_sel), ANIM_SAD);
                 chk("rr_g2_step", 32'(step), 0);

    // Retrigger during anim 2 at loop_cnt=1
    adv_to(400); chk("rt_loop1_ld", 32'(loop_done), 1);
    adv_to(404); req = 4'b0100;
    adv_to(405); req = 4'b0000;
    chk("rt_no_grant", 32'(grant), 0);
    adv_to(464); chk("rt_extended_sel", 32'(anim_sel), ANIM_SAD);
                 chk("rt_extended_ld", 32'(loop_done), 1);
    adv_to(527); req = 4'b1000;
    adv_to(528); req = 4'b0000;
    chk("rr_g3_grant", 32'(grant), 32'h8);
    chk("rr_g3_sel", 32'(anim_sel), ANIM_ANGRY);
    adv_to(592); chk("g3_loop1_sel", 32'(anim_sel), ANIM_ANGRY);
    adv_to(655); chk("g3_e655_busy", 32'(busy), 1);
    adv_to(656); chk("absorb_idle_sel", 32'(anim_sel), ANIM_IDLE);
                 chk("absorb_idle_busy", 32'(busy), 0);
                 chk("absorb_no_grant", 32'(grant), 0);

    // Asynchronous reset mid-PLAY drops pending requests
    adv_to(657); req = 4'b0010;
    adv_to(658); req = 4'b0000;
    chk("ar_grant", 32'(anim_sel), ANIM_HAPPY);
    adv_to(659); req = 4'b0100;
    adv_to(660); req = 4'b0000;
    adv_to(665); chk("ar_pre_step", 32'(step), 2);
                 chk("ar_pre_busy", 32'(busy), 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("ar_async_sel", 32'(anim_sel), ANIM_IDLE);
    chk("ar_async_step", 32'(step), 0);
    chk("ar_async_busy", 32'(busy), 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    edge_n = 0;
    adv_to(2);   chk("ar_drop_grant", 32'(grant), 0);
                 chk("ar_drop_busy", 32'(busy), 0);
    adv_to(8);   chk("ar_drop_busy_late", 32'(busy), 0);
                 chk("ar_drop_sel", 32'(anim_sel), ANIM_IDLE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
